// File: rtl/mem_access_master.sv
// mem_access_master
// Initiator-side engine for a single-port parity memory. It takes write and
// read commands from a valid/ready command channel and turns each one into a
// one-cycle memory strobe. Reads come back on a valid/ready response channel
// with the data, the parity bit stripped, and a parity-error flag.
//
// Handshake rule (both channels): a transfer happens on the posedge where
// valid & ready are both 1. A producer holds valid and its payload stable
// until that edge and never drops valid without a transfer.
//
// Ports
//   clk, rst_n              clock (posedge), asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write               1 = write, 0 = read
//   cmd_addr, cmd_wdata     command address and write data
//   rsp_valid/rsp_ready     read response handshake
//   rsp_rdata, rsp_perr     read data and parity-mismatch flag
//   mem_write, mem_read     memory strobes (one cycle each, never together)
//   mem_address             latched memory address
//   mem_data_in             latched memory write data
//   mem_data_out            memory read word, MSB = even parity; registered by
//                           the memory on the posedge where mem_read=1
//   err_count               saturating parity-error count
//   busy                    engine is not idle
//   dbg_state               current FSM state (IDLE=0 WR=1 RD=2 CAP=3 RSP=4)
//
// Build option
//   MEM_ACCESS_MASTER_PARITY_CHECK_EN: when defined the parity bit is checked
//   and rsp_perr/err_count are live. When undefined the parity bit is ignored
//   and rsp_perr/err_count stay 0. Timing is identical either way.
module mem_access_master #(
  parameter int AW  = 16,
  parameter int DW  = 8,
  parameter int ECW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [AW-1:0]  cmd_addr,
  input  logic [DW-1:0]  cmd_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_rdata,
  output logic           rsp_perr,
  output logic           mem_write,
  output logic           mem_read,
  output logic [AW-1:0]  mem_address,
  output logic [DW-1:0]  mem_data_in,
  input  logic [DW:0]    mem_data_out,
  output logic [ECW-1:0] err_count,
  output logic           busy,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_RSP  = 3'd4
  } state_e;

  state_e         state_q,  state_d;
  logic [AW-1:0]  addr_q,   addr_d;
  logic [DW-1:0]  wdata_q,  wdata_d;
  logic [DW-1:0]  rdata_q,  rdata_d;
  logic           perr_q,   perr_d;
  logic [ECW-1:0] errcnt_q, errcnt_d;
  logic           perr_now;

`ifdef MEM_ACCESS_MASTER_PARITY_CHECK_EN
  // Even parity: the stored MSB equals the XOR of the data bits, so a
  // mismatch shows up as a 1 when everything is XORed together.
  assign perr_now = mem_data_out[DW] ^ (^mem_data_out[DW-1:0]);
`else
  // With checking disabled perr_now is constant 0, so the flag and counter
  // registers below collapse to constants.
  logic unused_parity_bit;
  assign unused_parity_bit = mem_data_out[DW];
  assign perr_now          = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    perr_d   = perr_q;
    errcnt_d = errcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = cmd_write ? S_WR : S_RD;
        end
      end
      S_WR:  state_d = S_IDLE;
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        // Memory registered the word on the RD edge, so it is valid now.
        rdata_d = mem_data_out[DW-1:0];
        perr_d  = perr_now;
        if (perr_now && (errcnt_q != {ECW{1'b1}})) begin
          errcnt_d = errcnt_q + {{(ECW-1){1'b0}}, 1'b1};
        end
        state_d = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      perr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      perr_q   <= perr_d;
      errcnt_q <= errcnt_d;
    end
  end

  // Strobes and handshake signals decode straight from the state register,
  // so they are glitch-free and clear the moment reset asserts.
  assign cmd_ready   = (state_q == S_IDLE);
  assign mem_write   = (state_q == S_WR);
  assign mem_read    = (state_q == S_RD);
  assign rsp_valid   = (state_q == S_RSP);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_perr    = perr_q;
  assign err_count   = errcnt_q;

endmodule

// File: tb/tb_mem_access_master.sv
module tb_mem_access_master;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int ECW = 2;

`ifdef MEM_ACCESS_MASTER_PARITY_CHECK_EN
  localparam bit PERR_LIVE = 1'b1;
`else
  localparam bit PERR_LIVE = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;
  logic           rsp_valid, rsp_ready;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_perr;
  logic           mem_write, mem_read;
  logic [AW-1:0]  mem_address;
  logic [DW-1:0]  mem_data_in;
  logic [DW:0]    mem_data_out = '0;
  logic [ECW-1:0] err_count;
  logic           busy;
  logic [2:0]     dbg_state;

  always #5 clk = ~clk;

  mem_access_master #(.AW(AW), .DW(DW), .ECW(ECW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .err_count(err_count),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int             n_checks = 0;
  int             n_errors = 0;
  logic [DW:0]    exp_q[$];          // {perr, rdata} per expected response
  logic [ECW-1:0] exp_err = '0;
  logic [8:0]     mem_model [int];
  bit             inject_perr = 1'b0;
  logic           prev_wr = 1'b0;
  logic [DW:0]    mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- memory model (even-parity word) ----------------
  always @(posedge clk) begin
    logic [8:0] w;
    if (mem_write) mem_model[int'(mem_address)] = {^mem_data_in, mem_data_in};
    if (mem_read) begin
      w = mem_model.exists(int'(mem_address)) ? mem_model[int'(mem_address)] : 9'h000;
      if (inject_perr) w[8] = ~w[8];
      mem_data_out <= w;
    end
  end

  // ---------------- monitor + scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr <= 1'b0;
    end else begin
      check("strobe_exclusive", 32'(mem_write & mem_read), 32'(0));
      check("ready_only_idle", 32'(cmd_ready), 32'(!busy));
      check("write_one_cycle", 32'(prev_wr & mem_write), 32'(0));
      prev_wr <= mem_write;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e[DW-1:0]));
          check("rsp_perr", 32'(rsp_perr), 32'(mon_e[DW]));
        end
      end
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic do_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit push_rsp, input logic [DW:0] exp_word);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail_now("cmd_accept_timeout");
    else if (push_rsp) exp_q.push_back(exp_word);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 16'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) fail_now("idle_timeout");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            inj;
    logic [DW-1:0] exp_rdata;
    bit            exp_perr;
  } vec_t;

  vec_t          vecs[$];
  vec_t          v;
  logic [AW-1:0] ra [6];
  logic [DW-1:0] rd [6];

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Random writes to distinct addresses, then reads back in reverse order.
    for (int i = 0; i < 6; i++) begin
      ra[i] = {3'(i + 1), 13'($urandom)};
      rd[i] = 8'($urandom);
      v = '{1'b1, ra[i], rd[i], 1'b0, 8'h00, 1'b0};
      vecs.push_back(v);
    end
    for (int i = 5; i >= 0; i--) begin
      v = '{1'b0, ra[i], 8'h00, 1'b0, rd[i], 1'b0};
      vecs.push_back(v);
    end
    // Parity injections on 0x1234 (holds 0xA5); five of them saturate a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      v = '{1'b0, 16'h1234, 8'h00, 1'b1, 8'hA5, PERR_LIVE};
      vecs.push_back(v);
    end

    // ---- reset ----
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_mem_write", 32'(mem_write), 32'(0));
    check("rst_mem_read", 32'(mem_read), 32'(0));
    check("rst_mem_address", 32'(mem_address), 32'(0));
    check("rst_mem_data_in", 32'(mem_data_in), 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- write 0x1234 <- 0xA5, strobe shape ----
    do_cmd(1'b1, 16'h1234, 8'hA5, 1'b0, '0);
    @(negedge clk);
    check("wr_strobe", 32'(mem_write), 32'(1));
    check("wr_addr", 32'(mem_address), 32'h1234);
    check("wr_data", 32'(mem_data_in), 32'hA5);
    @(negedge clk);
    check("wr_strobe_drop", 32'(mem_write), 32'(0));
    check("wr_back_idle", 32'(busy), 32'(0));
    check("addr_retained", 32'(mem_address), 32'h1234);
    check("data_retained", 32'(mem_data_in), 32'hA5);
    @(posedge clk);
    #1;

    // ---- read 0x1234, latency RD, CAP, RSP ----
    do_cmd(1'b0, 16'h1234, 8'h00, 1'b1, {1'b0, 8'hA5});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("rsp_latency", 32'(rsp_valid), 32'(k == 3));
      if (k == 1) check("rd_strobe", 32'(mem_read), 32'(1));
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    wait_idle();

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      inject_perr = vecs[i].inj;
      if (vecs[i].wr) begin
        do_cmd(1'b1, vecs[i].addr, vecs[i].data, 1'b0, '0);
      end else begin
        do_cmd(1'b0, vecs[i].addr, 8'($urandom), 1'b1, {vecs[i].exp_perr, vecs[i].exp_rdata});
        if (vecs[i].inj && PERR_LIVE && (exp_err != {ECW{1'b1}})) exp_err = exp_err + 1'b1;
      end
      wait_idle();
      inject_perr = 1'b0;
      check("err_count", 32'(err_count), 32'(exp_err));
    end

    // ---- backpressure on a read of 0x3C ----
    do_cmd(1'b1, 16'h0BEE, 8'h3C, 1'b0, '0);
    wait_idle();
    rsp_ready = 1'b0;
    do_cmd(1'b0, 16'h0BEE, 8'h00, 1'b1, {1'b0, 8'h3C});
    begin
      int n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!rsp_valid) fail_now("rsp_valid_timeout");
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
      check("bp_rsp_rdata", 32'(rsp_rdata), 32'h3C);
      check("bp_cmd_ready", 32'(cmd_ready), 32'(0));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_after", 32'(dbg_state), 32'(0));
    check("bp_not_busy", 32'(busy), 32'(0));

    // ---- reset during CAP ----
    do_cmd(1'b1, 16'h7777, 8'h5A, 1'b0, '0);
    wait_idle();
    do_cmd(1'b0, 16'h7777, 8'h00, 1'b0, '0);
    @(posedge clk);
    #1;
    check("in_cap", 32'(dbg_state), 32'(3));
    #2;
    rst_n = 1'b0;
    #1;
    exp_err = '0;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_mem_read", 32'(mem_read), 32'(0));
    check("mid_rst_mem_address", 32'(mem_address), 32'(0));
    check("mid_rst_mem_data_in", 32'(mem_data_in), 32'(0));
    check("mid_rst_err_count", 32'(err_count), 32'(0));
    check("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'(0));
    end
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("post_rst_err_count", 32'(err_count), 32'(exp_err));

    // ---- report ----
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
